// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU.
// One quotient bit per cycle; result is {remainder, quotient}.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t state_q, state_n;

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH:0]   shreg_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic               neg1_q;
    logic               neg2_q;
    logic               sgn_q;

    logic               accept;
    logic               op2_zero;
    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH:0]   step_val;
    logic               cnt_done;
    logic [WIDTH-1:0]   quot_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;

    // Operand conditioning, one restoring step, and sign fix-up.
    always_comb begin
        accept   = start_i && !annul_i;
        op2_zero = (opdata2_i == '0);
        op1_neg  = signed_div_i && opdata1_i[WIDTH-1];
        op2_neg  = signed_div_i && opdata2_i[WIDTH-1];
        abs1     = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        abs2     = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

        // Extra top bit of diff is the borrow of the trial subtract.
        diff = {1'b0, shreg_q[2*WIDTH:WIDTH]} - {2'b00, dvsr_q};
        if (diff[WIDTH+1]) begin
            step_val = {shreg_q[2*WIDTH-1:0], 1'b0};
        end else begin
            step_val = {diff[WIDTH-1:0], shreg_q[WIDTH-1:0], 1'b1};
        end

        cnt_done = (cnt_q == CW'(WIDTH));
        quot_raw = shreg_q[WIDTH-1:0];
        rem_raw  = shreg_q[2*WIDTH:WIDTH+1];

        // Truncating division: remainder follows the dividend's sign.
        if (sgn_q && (neg1_q ^ neg2_q)) begin
            quot_fin = ~quot_raw + 1'b1;
        end else begin
            quot_fin = quot_raw;
        end
        if (sgn_q && neg1_q) begin
            rem_fin = ~rem_raw + 1'b1;
        end else begin
            rem_fin = rem_raw;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            FREE: begin
                if (accept) begin
                    state_n = op2_zero ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_n = END;
            end
            ON: begin
                if (annul_i) begin
                    state_n = FREE;
                end else if (cnt_done) begin
                    state_n = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_n = FREE;
                end
            end
            default: begin
                state_n = FREE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_n;
        end
    end

    // Operand capture: magnitudes and signs latched at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvsr_q <= '0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            sgn_q  <= 1'b0;
        end else if (state_q == FREE && accept && !op2_zero) begin
            dvsr_q <= abs2;
            neg1_q <= op1_neg;
            neg2_q <= op2_neg;
            sgn_q  <= signed_div_i;
        end
    end

    // Shift register and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (state_q == FREE) begin
            if (accept && !op2_zero) begin
                shreg_q <= {{WIDTH{1'b0}}, abs1, 1'b0};
                cnt_q   <= '0;
            end
        end else if (state_q == ON && !annul_i && !cnt_done) begin
            shreg_q <= step_val;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Registered result and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            unique case (state_q)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
                BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ON: begin
                    if (annul_i || !cnt_done) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        result_o <= {rem_fin, quot_fin};
                        ready_o  <= 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus multi-cycle
// corner-case sequences for div_unit.
module tb_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          signed_div;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic          start;
    logic          annul;
    logic [2*W-1:0] result;
    logic          ready;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    typedef struct {
        logic          sgn;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [63:0]   exp;
        int            lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 100);
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        annul      = 1'b0;
        start      = 1'b1;
    endtask

    task automatic release_start(input string name);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_rel_ready"}, 64'(ready), 64'd0);
        chk({name, "_rel_result"}, result, 64'd0);
    endtask

    task automatic watch_idle(input string name);
        int seen;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] keep;

        vecs[0] = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34};
        vecs[1] = '{1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 34};
        vecs[2] = '{1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 34};
        vecs[3] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34};
        vecs[4] = '{1'b0, 32'hFFFFFF9C, 32'd7, 64'h00000002_24924916, 34};
        vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34};
        vecs[7] = '{1'b0, 32'd5, 32'd9, 64'h00000005_00000000, 34};
        vecs[8] = '{1'b0, 32'h1234, 32'd0, 64'd0, 2};
        vecs[9] = '{1'b1, 32'h1234, 32'd0, 64'd0, 2};

        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_ready(n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), result, vecs[i].exp);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_hold_ready", i), 64'(ready), 64'd1);
            chk($sformatf("v%0d_hold_result", i), result, vecs[i].exp);
            release_start($sformatf("v%0d", i));
        end

        // Annul ten cycles into an operation, then a fresh divide.
        launch(1'b0, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        watch_idle("annul_noready");
        launch(1'b0, 32'd50, 32'd5);
        wait_ready(n);
        chk("post_annul_latency", 64'(n), 64'd34);
        chk("post_annul_result", result, 64'h00000000_0000000A);
        release_start("post_annul");

        // Reset in the middle of an operation.
        launch(1'b1, 32'hFFFFFF9C, 32'd7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_on_ready", 64'(ready), 64'd0);
        chk("rst_on_result", result, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        watch_idle("rst_on_noready");

        // Reset while holding a result.
        launch(1'b0, 32'd100, 32'd7);
        wait_ready(n);
        chk("rst_end_pre", result, 64'h00000002_0000000E);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_end_ready", 64'(ready), 64'd0);
        chk("rst_end_result", result, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_end_after", 64'(ready), 64'd0);

        // Operand changes after acceptance; annul in END ignored.
        launch(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        op1        = 32'hDEAD;
        op2        = 32'd0;
        signed_div = 1'b1;
        wait_ready(n);
        chk("opchg_latency", 64'(n), 64'd33);
        chk("opchg_result", result, 64'h00000002_0000000E);
        keep = result;
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        chk("end_annul_ready", 64'(ready), 64'd1);
        chk("end_annul_result", result, keep);
        @(negedge clk);
        annul = 1'b0;
        release_start("opchg");

        // Start dropped during ON: completes, one cycle in END.
        launch(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_ready(n);
        chk("drop_latency", 64'(n), 64'd33);
        chk("drop_result", result, 64'h00000002_0000000E);
        @(posedge clk);
        #1;
        chk("drop_ready_after", 64'(ready), 64'd0);
        chk("drop_result_after", result, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
